twiddle_rf_loader: RTL and testbench
====================================

# twiddle_rf_loader

Write-side loader for the twiddle-factor register file that the DTFAG read path consumes. It accepts a stream of `D_width twiddle words over a valid/ready handshake and turns each word into one registered write strobe with ROM select, bank and row address. It fills ROM0..ROM2 × 16 banks × ROW_NUM rows in a fixed order. While loading, it holds the read-side chip enable inactive, so the FFT datapath cannot read a partially written table.

## Interface
- ROM_NUM, 3, number of ROM images (ROM0..ROM2)
- BANK_NUM, 16, banks per ROM (b0..b15)
- ROW_NUM, 1<<`ROMA_width, rows per bank
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a full load; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no further writes
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- in_data  in  `D_width  twiddle word
- WE  out  1  write strobe, one word per pulse
- W_rom  out  2  target ROM index 0..2
- W_bank  out  4  target bank 0..15
- W_addr  out  `ROMA_width  target row
- W_data  out  `D_width  write data
- ROM_CEN  out  1  read chip enable to register file, active-low; 1 while busy
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse with the final write

## Operation
- FSM states: IDLE, LOAD.
  - IDLE→LOAD on start (abort low); counters rom/row/bank clear to 0.
  - LOAD→IDLE on the final accepted word, or on abort.
- in_ready = (state==LOAD) & ~abort. A word is accepted when in_valid & in_ready.
- Fill order: bank is the fastest index, then row, then ROM. Order is (rom0,row0,b0..b15), (rom0,row1,…), …, (rom2,ROW_NUM-1,b15).
- Wrap-around:
  - bank==BANK_NUM-1 → bank=0, row+1.
  - row==ROW_NUM-1 as well → row=0, rom+1.
- Final word: rom==ROM_NUM-1 & row==ROW_NUM-1 & bank==BANK_NUM-1.
- start during LOAD is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- abort and an in_valid word in the same cycle: the word is not accepted (in_ready=0).
- Total accepted words per load = ROM_NUM*BANK_NUM*ROW_NUM.

## Timing
- Reset values: state=IDLE, all counters 0, WE=0, W_rom=0, W_bank=0, W_addr=0, W_data=0, ROM_CEN=1, busy=0, done=0, in_ready=0.
- Write latency 1: word accepted at edge k → WE=1 with its W_rom/W_bank/W_addr/W_data in cycle k+1. WE=0 in any cycle following no accept.
- Throughput: one word per cycle; in_valid gaps produce WE gaps without losing position.
- done=1 in the same cycle as the final WE; busy falls in that cycle.
- ROM_CEN:
  - Goes 1 the cycle after start is taken.
  - Returns to 0 one cycle after the final WE (write settles before reads).
  - After an abort it stays 1; the table is invalid until a complete load.
- rst_n low mid-load: immediate return to reset values; a partial table stays, ROM_CEN=1.

## Configuration
- TWIDDLE_LOADER_CHECKSUM_EN defined:
  - Adds output load_csum [`D_width-1:0].
  - XOR of all words accepted since the last start; cleared on start, held after done.
  - Reset value 0.
- Undefined: no port, no register; all other behaviour identical.

## Structure
- Shared package/define include holds the state encoding (IDLE=1'b0, LOAD=1'b1) and the ROM_NUM/BANK_NUM constants next to `D_width/`ROMA_width.
- One natural sub-module, twiddle_addr_cnt: the nested bank/row/rom counter with an inc input and outputs last_bank/last_row/last_word.
- FSM, handshake and output registers stay in the top.

## Test plan
- Reset, then start, stream 0..N-1 with in_valid held high → WE every cycle after the first accept. First write is (rom0,b0,row0,data0); write 16 is (rom0,b0,row1,data16). done and ROM_CEN=0 follow the final write (rom2,b15,row ROW_NUM-1).
- in_valid toggling 1,0,1,0 → WE pattern follows one cycle later; bank sequence 0,1,2… with no skips.
- Abort after 20 words → in_ready=0 that cycle, no WE after the 20th write, state IDLE, ROM_CEN=1, done never pulses. A new start restarts at (0,0,0).
- start pulsed during LOAD at word 5 → ignored; counters continue from bank 5.
- rst_n asserted mid-load → all outputs take reset values asynchronously; after release, start loads from (0,0,0).
- With TWIDDLE_LOADER_CHECKSUM_EN: words 0x1,0x2,0x4 then abort → load_csum=0x7; a new start clears it to 0.

Source files
------------

// File: rtl/twiddle_rf_loader_pkg.sv
// Shared constants and state encoding for the twiddle register-file loader.
// Word and row-address widths come from `D_width / `ROMA_width (defaults below).
`ifndef D_width
`define D_width 16
`endif
`ifndef ROMA_width
`define ROMA_width 2
`endif

package twiddle_rf_loader_pkg;
    localparam int D_WIDTH     = `D_width;
    localparam int ROMA_WIDTH  = `ROMA_width;
    localparam int ROM_NUM     = 3;
    localparam int BANK_NUM    = 16;
    localparam int ROW_NUM     = 1 << ROMA_WIDTH;
    localparam int TOTAL_WORDS = ROM_NUM * BANK_NUM * ROW_NUM;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;
endpackage

// File: rtl/twiddle_rf_loader_if.sv
// Input word stream plus register-file write bus of the twiddle loader.
// master = upstream source / write observer, slave = the loader itself.
interface twiddle_rf_loader_if;
    import twiddle_rf_loader_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [D_WIDTH-1:0]    in_data;
    logic                  WE;
    logic [1:0]            W_rom;
    logic [3:0]            W_bank;
    logic [ROMA_WIDTH-1:0] W_addr;
    logic [D_WIDTH-1:0]    W_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, WE, W_rom, W_bank, W_addr, W_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, WE, W_rom, W_bank, W_addr, W_data
    );
endinterface

// File: rtl/twiddle_rf_loader_addr_cnt.sv
// Nested bank/row/rom position counter: bank fastest, then row, then ROM.
// Wraps back to (0,0,0) after the final word of a full table.
module twiddle_addr_cnt
    import twiddle_rf_loader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [1:0]            o_rom,
    output logic [3:0]            o_bank,
    output logic [ROMA_WIDTH-1:0] o_row,
    output logic                  o_last_bank,
    output logic                  o_last_row,
    output logic                  o_last_word
);
    logic [1:0]            r_rom;
    logic [3:0]            r_bank;
    logic [ROMA_WIDTH-1:0] r_row;

    assign o_rom       = r_rom;
    assign o_bank      = r_bank;
    assign o_row       = r_row;
    assign o_last_bank = (r_bank == 4'(BANK_NUM - 1));
    assign o_last_row  = (r_row == ROMA_WIDTH'(ROW_NUM - 1));
    assign o_last_word = o_last_bank & o_last_row & (r_rom == 2'(ROM_NUM - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rom  <= '0;
            r_bank <= '0;
            r_row  <= '0;
        end else if (i_clr) begin
            r_rom  <= '0;
            r_bank <= '0;
            r_row  <= '0;
        end else if (i_inc) begin
            if (o_last_bank) begin
                r_bank <= '0;
                if (o_last_row) begin
                    r_row <= '0;
                    r_rom <= o_last_word ? 2'd0 : r_rom + 2'd1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_bank <= r_bank + 4'd1;
            end
        end
    end
endmodule

// File: rtl/twiddle_rf_loader.sv
// Twiddle-factor register-file loader: streams words into ROM0..2 x 16 banks x rows.
// Optional load checksum output enabled by TWIDDLE_LOADER_CHECKSUM_EN.
module twiddle_rf_loader
    import twiddle_rf_loader_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    twiddle_rf_loader_if.slave   bus,
    output logic                 o_rom_cen,
    output logic                 o_busy,
    output logic                 o_done
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    ,
    output logic [D_WIDTH-1:0]   o_load_csum
`endif
);
    state_e                r_state;
    logic                  r_rom_cen;
    logic                  r_done;
    logic                  w_load;
    logic                  w_start;
    logic                  w_accept;
    logic [1:0]            w_rom;
    logic [3:0]            w_bank;
    logic [ROMA_WIDTH-1:0] w_row;
    logic                  w_last_bank;
    logic                  w_last_row;
    logic                  w_last_word;

    assign w_load      = (r_state == LOAD);
    assign w_start     = (r_state == IDLE) & i_start & ~i_abort;
    assign bus.in_ready = w_load & ~i_abort;
    assign w_accept    = bus.in_valid & bus.in_ready;

    assign o_rom_cen = r_rom_cen;
    assign o_busy    = w_load;
    assign o_done    = r_done;

    twiddle_addr_cnt u_addr_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_start),
        .i_inc       (w_accept),
        .o_rom       (w_rom),
        .o_bank      (w_bank),
        .o_row       (w_row),
        .o_last_bank (w_last_bank),
        .o_last_row  (w_last_row),
        .o_last_word (w_last_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_rom_cen  <= 1'b1;
            r_done     <= 1'b0;
            bus.WE     <= 1'b0;
            bus.W_rom  <= '0;
            bus.W_bank <= '0;
            bus.W_addr <= '0;
            bus.W_data <= '0;
        end else begin
            bus.WE <= w_accept;
            r_done <= w_accept & w_last_word;
            if (w_accept) begin
                bus.W_rom  <= w_rom;
                bus.W_bank <= w_bank;
                bus.W_addr <= w_row;
                bus.W_data <= bus.in_data;
            end
            // Read enable is released only the cycle after the final write lands.
            if (w_start) begin
                r_rom_cen <= 1'b1;
            end else if (r_done) begin
                r_rom_cen <= 1'b0;
            end
            case (r_state)
                IDLE: if (w_start) r_state <= LOAD;
                LOAD: begin
                    if (i_abort || (w_accept && w_last_word)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    logic [D_WIDTH-1:0] r_csum;

    assign o_load_csum = r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_start) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end
`endif
endmodule

// File: tb/tb_twiddle_rf_loader.sv
// Self-checking bench for twiddle_rf_loader: control table plus write scoreboard.
module tb_twiddle_rf_loader;
    import twiddle_rf_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic rom_cen, busy, done;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    logic [D_WIDTH-1:0] load_csum;
`endif

    twiddle_rf_loader_if bus ();

    twiddle_rf_loader dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_abort   (abort),
        .bus       (bus),
        .o_rom_cen (rom_cen),
        .o_busy    (busy),
        .o_done    (done)
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        ,
        .o_load_csum (load_csum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_we = 0;

    typedef struct {
        int              rom;
        int              bank;
        int              row;
        logic [D_WIDTH-1:0] data;
        logic            done;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Bench-side model of the loader position
    logic m_load = 1'b0;
    int m_rom = 0, m_bank = 0, m_row = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic v, input logic [D_WIDTH-1:0] d);
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        start = s;
        abort = a;
        bus.in_valid = v;
        bus.in_data = d;
        exp_rdy = m_load & ~a;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            e.rom = m_rom; e.bank = m_bank; e.row = m_row; e.data = d;
            e.done = (m_rom == ROM_NUM-1) && (m_row == ROW_NUM-1) && (m_bank == BANK_NUM-1);
            q.push_back(e);
            if (e.done) m_load = 1'b0;
            m_bank++;
            if (m_bank == BANK_NUM) begin
                m_bank = 0;
                m_row++;
                if (m_row == ROW_NUM) begin
                    m_row = 0;
                    m_rom++;
                end
            end
        end else if (a) begin
            m_load = 1'b0;
        end else if (!m_load && s) begin
            m_load = 1'b1;
            m_rom = 0; m_bank = 0; m_row = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.WE) begin
                n_we++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got WE=1 bank=%0d data=%0h expected no write", bus.W_bank, bus.W_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("W_rom",  32'(bus.W_rom),  32'(mon_e.rom));
                    chk("W_bank", 32'(bus.W_bank), 32'(mon_e.bank));
                    chk("W_addr", 32'(bus.W_addr), 32'(mon_e.row));
                    chk("W_data", 32'(bus.W_data), 32'(mon_e.data));
                    chk("done",   32'(done),       32'(mon_e.done));
                end
            end else if (done) begin
                chk("done_without_we", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic start, abort, valid;
        logic [D_WIDTH-1:0] data;
        logic exp_we, exp_busy, exp_cen;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst_we", 32'(bus.WE), 32'd0);
        chk("rst_rom", 32'(bus.W_rom), 32'd0);
        chk("rst_bank", 32'(bus.W_bank), 32'd0);
        chk("rst_addr", 32'(bus.W_addr), 32'd0);
        chk("rst_data", 32'(bus.W_data), 32'd0);
        chk("rst_cen", 32'(rom_cen), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Control table: idle, start+abort, start, accept, gap, abort+valid, idle valid
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].data);
            @(posedge clk);
            #1;
            chk("tbl_we", 32'(bus.WE), 32'(tbl[i].exp_we));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
            chk("tbl_cen", 32'(rom_cen), 32'(tbl[i].exp_cen));
        end

        // Full load with in_valid held high
        drive(1'b1, 1'b0, 1'b0, '0);
        base = n_we;
        for (int i = 0; i < TOTAL_WORDS; i++) drive(1'b0, 1'b0, 1'b1, D_WIDTH'(i));
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("final_done", 32'(done), 32'd1);
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_cen_hold", 32'(rom_cen), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("post_cen", 32'(rom_cen), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("we_count", 32'(n_we - base), 32'(TOTAL_WORDS));

        // in_valid toggling; ROM_CEN rises after start
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 16'h0100);
        chk("start_cen", 32'(rom_cen), 32'd1);
        for (int i = 1; i < 9; i++) drive(1'b0, 1'b0, (i % 2) == 0, D_WIDTH'(16'h0100 + i));
        drive(1'b0, 1'b1, 1'b0, '0);

        // Abort after 20 words, then restart at (0,0,0)
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, D_WIDTH'(16'h0200 + i));
        drive(1'b0, 1'b1, 1'b1, 16'hBEEF);
        drive(1'b0, 1'b0, 1'b1, 16'hBEEE);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cen", 32'(rom_cen), 32'd1);
        chk("abort_we", 32'(bus.WE), 32'd0);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 16'h1234);
        drive(1'b0, 1'b0, 1'b1, 16'h1235);
        drive(1'b0, 1'b1, 1'b0, '0);

        // start during LOAD at word 5 is ignored
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, D_WIDTH'(16'h0300 + i));
        drive(1'b1, 1'b0, 1'b1, 16'h0305);
        for (int i = 6; i < 9; i++) drive(1'b0, 1'b0, 1'b1, D_WIDTH'(16'h0300 + i));
        drive(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset mid-load while WE is high
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, D_WIDTH'(16'h0400 + i));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.WE), 32'd0);
        chk("arst_bank", 32'(bus.W_bank), 32'd0);
        chk("arst_data", 32'(bus.W_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cen", 32'(rom_cen), 32'd1);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        q.delete();
        m_load = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 16'h0055);
        drive(1'b0, 1'b0, 1'b1, 16'h0056);
        drive(1'b0, 1'b1, 1'b0, '0);

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 16'h0001);
        drive(1'b0, 1'b0, 1'b1, 16'h0002);
        drive(1'b0, 1'b0, 1'b1, 16'h0004);
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("csum", 32'(load_csum), 32'h7);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("csum_clr", 32'(load_csum), 32'h0);
        drive(1'b0, 1'b1, 1'b0, '0);
`endif

        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
